servo_speed_sched: RTL and testbench
====================================

# servo_speed_sched

Scheduler that shares the single servo speed path between a manual requester (keypad) and an automatic requester (program sequencer), with a stop override. It drives the `speed_level`/`max_level` inputs of the servo pulse controller and watches that controller's `l_ctrl | r_ctrl` activity. Ownership only changes after the servo has been ramped to level 0 and has settled, so the speed setpoint never jumps between requesters.

## Interface
- `MAX_LEVEL`, 9: full-scale level; driven constantly on `max_level`. Requested levels are clamped to it.
- `HOLD_TICKS`, 1000: minimum cycles auto keeps ownership before manual may preempt it.
- `SETTLE_TICKS`, 200: consecutive idle cycles of `moving` required to finish a drain.
- `DRAIN_TIMEOUT`, 65535: watchdog limit in cycles (only with the macro).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `stop` in 1: level-sensitive stop override, highest priority.
- `man_req` in 1: manual requests ownership, level held.
- `man_level` in 4: manual speed level.
- `auto_req` in 1: auto requests ownership, level held.
- `auto_level` in 4: auto speed level.
- `moving` in 1: servo ramp activity (`l_ctrl | r_ctrl`).
- `man_gnt` out 1: manual owns the servo.
- `auto_gnt` out 1: auto owns the servo.
- `speed_level` out 4: setpoint to the servo controller.
- `max_level` out 4: constant `MAX_LEVEL[3:0]`.
- `owner` out 2: 0 none, 1 manual, 2 auto, 3 stopped.
- `fault` out 1: sticky drain-timeout flag.

## Operation
- **States**: IDLE, MAN, AUTO, DRAIN, STOPPED. Reset value is IDLE, with every output at 0 except `max_level`.
- **IDLE**:
  - `stop` goes to STOPPED.
  - Otherwise `man_req` goes to MAN. Manual beats auto when both are requested in the same cycle.
  - Otherwise `auto_req` goes to AUTO and clears the hold counter.
- **MAN**:
  - `man_gnt` = 1.
  - `speed_level` = min(`man_level`, `MAX_LEVEL`), tracked every cycle.
  - `stop` or `man_req` going low moves to DRAIN.
- **AUTO**:
  - `auto_gnt` = 1.
  - `speed_level` = min(`auto_level`, `MAX_LEVEL`).
  - The hold counter saturates at `HOLD_TICKS`.
  - `stop` or `auto_req` low moves to DRAIN.
  - `man_req` with hold counter == `HOLD_TICKS` moves to DRAIN (preemption). Before that, `man_req` is ignored.
- **DRAIN**:
  - Grants are 0 and `speed_level` = 0.
  - The settle counter increments while `moving` = 0 and clears to 0 whenever `moving` = 1.
  - Settle counter == `SETTLE_TICKS`-1 with `moving` = 0 exits: to STOPPED if `stop`, else to IDLE.
  - `stop` asserting during DRAIN does not restart the drain.
- **STOPPED**:
  - `owner` = 3, `speed_level` = 0, grants are 0.
  - `stop` low returns to IDLE. Pending requests re-arbitrate in IDLE on the following cycle.
- **Clamp**: comparison is unsigned 4-bit. When `MAX_LEVEL` = 0, `speed_level` is always 0.
- A requester dropping and re-raising its request while in DRAIN has no effect until IDLE.
- `rst_n` low in any state forces IDLE and zero outputs immediately. There is no drain on reset.

## Timing
- All outputs are registered.
- A request sampled in IDLE on edge N gives grant and `speed_level` valid after edge N+1.
- Request drop or `stop` sampled on edge N gives grant low and `speed_level` = 0 after edge N+1.
- Minimum DRAIN duration is `SETTLE_TICKS` cycles. Total handover from owner loss to the new grant is ≥ `SETTLE_TICKS`+2 cycles.
- Grants are one-hot or zero; both grants are never high together.
- Level changes by the current owner pass through with 1-cycle latency.

## Configuration
- **`SERVO_SCHED_WATCHDOG_EN` defined**:
  - A drain counter runs in DRAIN.
  - Reaching `DRAIN_TIMEOUT` cycles without settling sets `fault` = 1 and goes to STOPPED. The transition is taken even if `stop` = 0, in which case STOPPED exits on the next cycle to IDLE.
  - `fault` clears only on reset.
- **Undefined**: DRAIN waits indefinitely, `fault` is tied to 0, and there is no drain counter hardware.

## Structure
- Shared package `servo_pkg`:
  - state enum;
  - owner encoding constants (`OWN_NONE`, `OWN_MAN`, `OWN_AUTO`, `OWN_STOP`);
  - 4-bit level typedef;
  - `clamp_level` function.
- Sub-module `servo_settle_cnt`: parameterised consecutive-idle counter with clear and done outputs. Instantiated once for the settle count.

## Test plan
- **Reset and manual grant**: reset, then `man_req`=1, `man_level`=5 → after 1 cycle `man_gnt`=1, `owner`=1, `speed_level`=5, `max_level`=9.
- **Simultaneous requests and clamp**: `man_req`=`auto_req`=1 in IDLE → `man_gnt` only. Then `man_level`=15 → `speed_level`=9.
- **Hold-gated preemption**: auto owns; `man_req` at cycle 10 → no change until the hold counter reaches 1000, then DRAIN with `speed_level`=0. With `moving`=0 held, `man_gnt` rises `SETTLE_TICKS`+1 cycles later.
- **Settle restart**: in DRAIN pulse `moving`=1 at settle count 150 → counter restarts; exit occurs 200 idle cycles after the pulse.
- **Stop paths**: `stop` while MAN → DRAIN then STOPPED (`owner`=3). Release `stop` → IDLE. `rst_n` low mid-DRAIN → all outputs 0 asynchronously.
- **Watchdog** (`SERVO_SCHED_WATCHDOG_EN`): hold `moving`=1 in DRAIN with `DRAIN_TIMEOUT`=500 → `fault`=1 at cycle 500, STOPPED, `fault` persists until reset.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types for the servo speed scheduler: FSM states, owner codes, level type and clamp helper.
package servo_pkg;

    localparam int unsigned LEVEL_W = 4;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAN     = 3'd1,
        ST_AUTO    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_STOPPED = 3'd4
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_MAN  = 2'd1;
    localparam logic [1:0] OWN_AUTO = 2'd2;
    localparam logic [1:0] OWN_STOP = 2'd3;

    function automatic level_t clamp_level(input level_t lvl, input level_t max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

endpackage

// File: rtl/servo_settle_cnt.sv
// Consecutive-idle counter: done_c fires on the cycle that completes TICKS idle cycles in a row.
module servo_settle_cnt #(
    parameter int unsigned TICKS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_idle,
    output logic o_done_c
);

    localparam int unsigned LAST  = (TICKS > 0) ? TICKS - 1 : 0;
    localparam int unsigned CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_idle && (r_cnt != LAST_C)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done_c = !i_clear && i_idle && (r_cnt == LAST_C);

endmodule

// File: rtl/servo_speed_sched.sv
// Arbitrates the servo speed path between manual and auto requesters, draining to level 0 on handover.
// Optional drain watchdog enabled by defining SERVO_SCHED_WATCHDOG_EN.
module servo_speed_sched
    import servo_pkg::*;
#(
    parameter int unsigned MAX_LEVEL    = 9,
    parameter int unsigned HOLD_TICKS   = 1000,
    parameter int unsigned SETTLE_TICKS = 200
`ifdef SERVO_SCHED_WATCHDOG_EN
   ,parameter int unsigned DRAIN_TIMEOUT = 65535
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stop,
    input  logic       man_req,
    input  logic [3:0] man_level,
    input  logic       auto_req,
    input  logic [3:0] auto_level,
    input  logic       moving,
    output logic       man_gnt,
    output logic       auto_gnt,
    output logic [3:0] speed_level,
    output logic [3:0] max_level,
    output logic [1:0] owner,
    output logic       fault
);

    localparam level_t MAX_L = level_t'(MAX_LEVEL);
    localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(HOLD_TICKS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_settle_done_c;

    logic              r_man_gnt;
    logic              r_auto_gnt;
    level_t            r_speed;
    logic [1:0]        r_owner;
    logic              w_man_gnt;
    logic              w_auto_gnt;
    level_t            w_speed;
    logic [1:0]        w_owner;

    servo_settle_cnt #(
        .TICKS (SETTLE_TICKS)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  ((r_state != ST_DRAIN) || moving),
        .i_idle   (!moving),
        .o_done_c (w_settle_done_c)
    );

`ifdef SERVO_SCHED_WATCHDOG_EN
    localparam int unsigned TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

    logic [TMO_W-1:0] r_drain_cnt;
    logic             r_fault;
    logic             w_fault_set;
    logic             w_wd_expired_c;

    assign w_wd_expired_c = (r_state == ST_DRAIN) && (r_drain_cnt == TMO_LAST);

    // Drain age counter: only meaningful while in DRAIN, reset to 0 everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + TMO_W'(1) : '0;
            r_fault     <= r_fault | w_fault_set;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next state plus the output values to be registered on this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_man_gnt   = 1'b0;
        w_auto_gnt  = 1'b0;
        w_speed     = '0;
        w_owner     = OWN_NONE;
`ifdef SERVO_SCHED_WATCHDOG_EN
        w_fault_set = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (stop) begin
                    w_state_nxt = ST_STOPPED;
                end else if (man_req) begin
                    w_state_nxt = ST_MAN;
                end else if (auto_req) begin
                    w_state_nxt = ST_AUTO;
                    w_hold_nxt  = '0;
                end
            end
            ST_MAN: begin
                w_man_gnt = 1'b1;
                w_speed   = clamp_level(man_level, MAX_L);
                w_owner   = OWN_MAN;
                if (stop || !man_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_AUTO: begin
                w_auto_gnt = 1'b1;
                w_speed    = clamp_level(auto_level, MAX_L);
                w_owner    = OWN_AUTO;
                if (r_hold != HOLD_C) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
                if (stop || !auto_req || (man_req && (r_hold == HOLD_C))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_settle_done_c) begin
                    w_state_nxt = stop ? ST_STOPPED : ST_IDLE;
                end
`ifdef SERVO_SCHED_WATCHDOG_EN
                else if (w_wd_expired_c) begin
                    w_state_nxt = ST_STOPPED;
                    w_fault_set = 1'b1;
                end
`endif
            end
            ST_STOPPED: begin
                w_owner = OWN_STOP;
                if (!stop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_man_gnt  <= 1'b0;
            r_auto_gnt <= 1'b0;
            r_speed    <= '0;
            r_owner    <= OWN_NONE;
        end else begin
            r_man_gnt  <= w_man_gnt;
            r_auto_gnt <= w_auto_gnt;
            r_speed    <= w_speed;
            r_owner    <= w_owner;
        end
    end

    assign man_gnt     = r_man_gnt;
    assign auto_gnt    = r_auto_gnt;
    assign speed_level = r_speed;
    assign owner       = r_owner;
    assign max_level   = MAX_L;

endmodule

// File: tb/tb_servo_speed_sched.sv
// Randomized bench for servo_speed_sched against a cycle-count reference model of the scheduling rules.
module tb_servo_speed_sched;

    localparam int MAXL   = 9;
    localparam int HOLD   = 1000;
    localparam int SETTLE = 200;
    localparam int TMO    = 500;
`ifdef SERVO_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int M_IDLE = 0, M_MAN = 1, M_AUTO = 2, M_DRAIN = 3, M_STOP = 4;

    logic       clk = 1'b0;
    logic       rst_n, stop, man_req, auto_req, moving;
    logic [3:0] man_level, auto_level;
    logic       man_gnt, auto_gnt, fault;
    logic [3:0] speed_level, max_level;
    logic [1:0] owner;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_mode, m_hold, m_idle_run, m_age;
    int e_mg, e_ag, e_spd, e_own, e_fault;

    always #5 clk = ~clk;

    servo_speed_sched #(
        .MAX_LEVEL     (MAXL),
        .HOLD_TICKS    (HOLD),
        .SETTLE_TICKS  (SETTLE)
`ifdef SERVO_SCHED_WATCHDOG_EN
       ,.DRAIN_TIMEOUT (TMO)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stop        (stop),
        .man_req     (man_req),
        .man_level   (man_level),
        .auto_req    (auto_req),
        .auto_level  (auto_level),
        .moving      (moving),
        .man_gnt     (man_gnt),
        .auto_gnt    (auto_gnt),
        .speed_level (speed_level),
        .max_level   (max_level),
        .owner       (owner),
        .fault       (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int lvl);
        return (lvl > MAXL) ? MAXL : lvl;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_hold = 0; m_idle_run = 0; m_age = 0;
        e_mg = 0; e_ag = 0; e_spd = 0; e_own = 0; e_fault = 0;
    endtask

    task automatic enter_drain();
        m_mode = M_DRAIN; m_idle_run = 0; m_age = 0;
    endtask

    // One clock edge of the scheduling rules; outputs reflect the mode held during the cycle.
    task automatic model_step();
        bit preempt;
        e_mg  = (m_mode == M_MAN)  ? 1 : 0;
        e_ag  = (m_mode == M_AUTO) ? 1 : 0;
        e_own = (m_mode == M_MAN) ? 1 : (m_mode == M_AUTO) ? 2 : (m_mode == M_STOP) ? 3 : 0;
        e_spd = (m_mode == M_MAN)  ? clamp(int'(man_level)) :
                (m_mode == M_AUTO) ? clamp(int'(auto_level)) : 0;
        case (m_mode)
            M_IDLE: begin
                if (stop) m_mode = M_STOP;
                else if (man_req) m_mode = M_MAN;
                else if (auto_req) begin m_mode = M_AUTO; m_hold = 0; end
            end
            M_MAN: if (stop || !man_req) enter_drain();
            M_AUTO: begin
                preempt = man_req && (m_hold >= HOLD);
                m_hold = (m_hold + 1 > HOLD) ? HOLD : m_hold + 1;
                if (stop || !auto_req || preempt) enter_drain();
            end
            M_DRAIN: begin
                m_idle_run = moving ? 0 : m_idle_run + 1;
                m_age++;
                if (!moving && m_idle_run == SETTLE) m_mode = stop ? M_STOP : M_IDLE;
                else if (WD && m_age == TMO) begin m_mode = M_STOP; e_fault = 1; end
            end
            default: if (!stop) m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        check("man_gnt",     32'(man_gnt),     e_mg);
        check("auto_gnt",    32'(auto_gnt),    e_ag);
        check("speed_level", 32'(speed_level), e_spd);
        check("owner",       32'(owner),       e_own);
        check("fault",       32'(fault),       e_fault);
        check("max_level",   32'(max_level),   MAXL);
        check("onehot_gnt",  32'(man_gnt & auto_gnt), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_man_gnt"},  32'(man_gnt),     0);
        check({tag, "_auto_gnt"}, 32'(auto_gnt),    0);
        check({tag, "_speed"},    32'(speed_level), 0);
        check({tag, "_owner"},    32'(owner),       0);
        check({tag, "_fault"},    32'(fault),       0);
        check({tag, "_max"},      32'(max_level),   MAXL);
    endtask

    // Entered and left at a negedge: drive, edge, model, then compare.
    task automatic cycle(input logic s, input logic m, input logic a, input int mv);
        stop       = s;
        man_req    = m;
        auto_req   = a;
        man_level  = 4'($urandom_range(0, 15));
        auto_level = 4'($urandom_range(0, 15));
        case (mv)
            0:       moving = 1'b0;
            1:       moving = ($urandom_range(0, 7) == 0);
            2:       moving = ($urandom_range(0, 7) != 0);
            default: moving = 1'b1;
        endcase
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n, input logic s, input logic m, input logic a, input int mv);
        for (int i = 0; i < n; i++) cycle(s, m, a, mv);
    endtask

    // Asynchronous reset asserted between edges, observed before the next edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stop = 1'b0; man_req = 1'b0; auto_req = 1'b0; moving = 1'b0;
        man_level = 4'd0; auto_level = 4'd0;
        model_reset();
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // manual grant, simultaneous requests, handover to auto
        run(3, 0, 1, 0, 0);
        run(4, 0, 1, 1, 0);
        run(1, 0, 0, 1, 0);
        run(215, 0, 0, 1, 0);
        // hold-gated preemption, then manual owns after settle
        run(10, 0, 0, 1, 0);
        run(1250, 0, 1, 1, 0);
        // settle restart by a moving pulse mid-drain
        run(1, 0, 0, 0, 0);
        run(150, 0, 0, 0, 0);
        run(1, 0, 0, 0, 3);
        run(205, 0, 0, 0, 0);
        // stop while manual: drain, stopped, release
        run(5, 0, 1, 0, 0);
        run(210, 1, 1, 0, 0);
        run(4, 0, 1, 0, 0);
        // reset in the middle of a drain
        run(60, 0, 0, 0, 0);
        async_reset("drain_rst");
        // moving held during a drain (watchdog path when enabled)
        run(5, 0, 1, 0, 0);
        run(520, 0, 0, 0, 3);
        run(20, 0, 0, 0, 0);
        async_reset("post_wd_rst");

        // random segments of held request patterns
        for (int seg = 0; seg < 30; seg++) begin
            int len;
            logic s, m, a;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(900, 1300)) : int'($urandom_range(1, 300));
            s = ($urandom_range(0, 5) == 0);
            m = $urandom_range(0, 1) != 0;
            a = $urandom_range(0, 1) != 0;
            run(len, s, m, a, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
